// File: rtl/ts_bram_arbiter.sv
// Shares one single-port BRAM between 64-bit timestamp captures (two word writes)
// and CPU register-port accesses. Timestamps win arbitration, but a CPU request always follows a capture.
module ts_bram_arbiter #(
  parameter  int G_MEMDEPTH = 1024,
  localparam int MAW        = $clog2(G_MEMDEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sync_edge,
  input  logic [63:0]    free_count,
  input  logic           ts_clear,
  input  logic           cpu_req,
  input  logic           cpu_req_is_wr,
  input  logic [MAW+1:0] cpu_addr,
  input  logic [31:0]    cpu_wr_data,
  output logic           cpu_rd_ack,
  output logic           cpu_wr_ack,
  output logic [31:0]    cpu_rd_data,
  output logic           mem_en,
  output logic           mem_we,
  output logic [MAW-1:0] mem_addr,
  output logic [31:0]    mem_wdata,
  input  logic [31:0]    mem_rdata,
  output logic [MAW-1:0] wr_ptr,
  output logic [15:0]    drop_count
);

  typedef enum logic [2:0] {S_IDLE, S_TS_LO, S_TS_HI, S_CPU, S_CPU_ACK} state_t;

  state_t         state_q, state_d;
  logic           ts_pending_q, cpu_pending_q, cpu_is_wr_q;
  logic [63:0]    snapshot_q;
  logic [MAW-1:0] wr_ptr_q, cpu_waddr_q;
  logic [31:0]    cpu_wdata_q;
  logic [15:0]    drop_cnt_q;
  logic           in_ts_hi, ts_accept, ts_drop, cpu_accept;
  logic           unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign in_ts_hi   = (state_q == S_TS_HI);
  // TS_HI retires the pending capture, so an edge landing there is a new capture.
  assign ts_accept  = sync_edge && (!ts_pending_q || in_ts_hi);
  assign ts_drop    = sync_edge && !ts_accept;
  assign cpu_accept = cpu_req && !cpu_pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ts_pending_q  <= 1'b0;
      cpu_pending_q <= 1'b0;
      cpu_is_wr_q   <= 1'b0;
      snapshot_q    <= '0;
      wr_ptr_q      <= '0;
      cpu_waddr_q   <= '0;
      cpu_wdata_q   <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q <= state_d;

      if (ts_accept) begin
        snapshot_q   <= free_count;
        ts_pending_q <= 1'b1;
      end else if (in_ts_hi) begin
        ts_pending_q <= 1'b0;
      end

      if (cpu_accept) begin
        cpu_pending_q <= 1'b1;
        cpu_is_wr_q   <= cpu_req_is_wr;
        cpu_waddr_q   <= cpu_addr[MAW+1:2];
        cpu_wdata_q   <= cpu_wr_data;
      end else if (state_q == S_CPU_ACK) begin
        cpu_pending_q <= 1'b0;
      end

      // Clear beats both the pointer advance and the drop increment.
      if (ts_clear) begin
        wr_ptr_q   <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (in_ts_hi) wr_ptr_q <= wr_ptr_q + MAW'(2);
        if (ts_drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_rd_ack  = 1'b0;
    cpu_wr_ack  = 1'b0;
    cpu_rd_data = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (ts_pending_q)       state_d = S_TS_LO;
          else if (cpu_pending_q) state_d = S_CPU;
        end
        S_TS_LO: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_ptr_q;
          mem_wdata = snapshot_q[31:0];
          state_d   = S_TS_HI;
        end
        S_TS_HI: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_ptr_q + MAW'(1);
          mem_wdata = snapshot_q[63:32];
          state_d   = cpu_pending_q ? S_CPU : S_IDLE;
        end
        S_CPU: begin
          mem_en    = 1'b1;
          mem_we    = cpu_is_wr_q;
          mem_addr  = cpu_waddr_q;
          mem_wdata = cpu_wdata_q;
          state_d   = S_CPU_ACK;
        end
        S_CPU_ACK: begin
          cpu_wr_ack = cpu_is_wr_q;
          cpu_rd_ack = !cpu_is_wr_q;
          if (!cpu_is_wr_q) cpu_rd_data = mem_rdata;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign wr_ptr     = rst ? '0 : wr_ptr_q;
  assign drop_count = rst ? '0 : drop_cnt_q;

endmodule

// File: doc/ts_bram_arbiter.md
TS_BRAM_ARBITER -- requirements
Module: ts_bram_arbiter

Interface
REQ-001 Parameter G_MEMDEPTH, default 1024, SHALL set the word depth of the shared memory; power of two, at least 4; MAW = clog2(G_MEMDEPTH).
REQ-002 Port clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 Port rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 sync_edge  in  1  SHALL be a one-cycle capture-request pulse.
REQ-005 free_count  in  64  SHALL be the free-running timestamp sampled on sync_edge.
REQ-006 ts_clear  in  1  SHALL be a one-cycle pulse that clears wr_ptr and drop_count.
REQ-007 cpu_req  in  1  SHALL be a one-cycle CPU access request pulse from the register block external port.
REQ-008 cpu_req_is_wr  in  1  SHALL be the write (1) / read (0) qualifier, valid with cpu_req.
REQ-009 cpu_addr  in  MAW+2  SHALL be the byte address, valid with cpu_req; bits [1:0] are ignored.
REQ-010 cpu_wr_data  in  32  SHALL be the write data, valid with cpu_req.
REQ-011 cpu_rd_ack / cpu_wr_ack  out  1 each  SHALL be one-cycle completion pulses.
REQ-012 cpu_rd_data  out  32  SHALL be the read data, valid only while cpu_rd_ack=1 and 0 otherwise.
REQ-013 mem_en, mem_we  out  1 each; mem_addr  out  MAW; mem_wdata  out  32; mem_rdata  in  32 -- SHALL form the single-port memory interface, with mem_rdata valid one cycle after an mem_en=1, mem_we=0 access.
REQ-014 wr_ptr  out  MAW  SHALL be the next timestamp word address; drop_count  out  16  SHALL count dropped captures.

Function
REQ-015 A sync_edge SHALL latch free_count into a 64-bit snapshot and set ts_pending, provided ts_pending=0.
REQ-016 A sync_edge while ts_pending=1 SHALL be dropped: the snapshot is unchanged and drop_count increments, saturating at 0xFFFF.
REQ-017 A cpu_req while cpu_pending=0 SHALL latch is_wr, addr[MAW+1:2] and wr_data, and set cpu_pending.
REQ-018 A cpu_req while cpu_pending=1 SHALL be ignored, with no latch and no ack.
REQ-019 The FSM SHALL have the states IDLE, TS_LO, TS_HI, CPU, CPU_ACK.
REQ-020 From IDLE: ts_pending -> TS_LO; else cpu_pending -> CPU; else stay in IDLE. Timestamp capture has priority.
REQ-021 TS_LO SHALL drive mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=snapshot[31:0], then go to TS_HI.
REQ-022 TS_HI SHALL drive mem_en=1, mem_we=1, mem_addr=wr_ptr+1, mem_wdata=snapshot[63:32].
REQ-023 In TS_HI, wr_ptr SHALL advance by 2 modulo G_MEMDEPTH (wrap to 0) and ts_pending SHALL clear.
REQ-024 From TS_HI the FSM SHALL go to CPU if cpu_pending=1, else to IDLE, so the CPU is never starved by back-to-back captures.
REQ-025 A sync_edge that coincides with the TS_HI cycle SHALL be accepted as a new capture, not dropped.
REQ-026 CPU SHALL drive mem_en=1, mem_we=latched is_wr, mem_addr=latched word address, mem_wdata=latched data, then go to CPU_ACK.
REQ-027 CPU_ACK SHALL pulse cpu_rd_ack with cpu_rd_data=mem_rdata for a read, or pulse cpu_wr_ack for a write; it then clears cpu_pending and returns to IDLE.
REQ-028 Outside TS_LO, TS_HI and CPU, mem_en and mem_we SHALL be 0 and mem_addr and mem_wdata SHALL be 0.
REQ-029 Uncontended CPU latency SHALL be 3 cycles from cpu_req to ack; with a pending capture ahead of it, latency SHALL be 5 cycles.
REQ-030 ts_clear SHALL set wr_ptr=0 and drop_count=0 on the next edge and SHALL take precedence over a coincident TS_HI advance or drop increment.
REQ-031 CPU writes SHALL NOT modify wr_ptr; CPU and timestamp writes to the same word are last-writer-wins.

Reset
REQ-032 While rst=1 the block SHALL set: FSM=IDLE, ts_pending=0, cpu_pending=0, snapshot=0, wr_ptr=0, drop_count=0.
REQ-033 While rst=1 all outputs SHALL be 0, and no ack SHALL be issued for a request in flight.
REQ-034 sync_edge and cpu_req asserted during rst=1 SHALL be ignored.

Verification
REQ-035 Isolated capture: free_count=0x1122334455667788, sync_edge pulse -> words 0=0x55667788 and 1=0x11223344 are written on consecutive cycles, then wr_ptr=2.
REQ-036 CPU read at byte address 0x4 with the memory idle -> mem_addr=1 read issued at cycle +2, then cpu_rd_ack with cpu_rd_data=0x11223344 at cycle +3.
REQ-037 sync_edge and cpu_req in the same cycle -> TS_LO, TS_HI, CPU, then ack at cycle +5; a second sync_edge on the cycle after the first -> drop_count=1.
REQ-038 Wrap: G_MEMDEPTH=1024, 512 spaced captures -> wr_ptr returns to 0 and the next capture overwrites words 0 and 1.
REQ-039 rst asserted during TS_HI or CPU_ACK -> no ack, wr_ptr=0, FSM=IDLE; the next request completes normally.
REQ-040 ts_clear coincident with TS_HI and drop_count=0xFFFF -> wr_ptr=0 and drop_count=0.
